// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit sequencer.
package uart_ctrl_pkg;

  localparam int unsigned LEN_W_DEF = 10;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned GAP_CNT_W = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StWaitRd = 3'd2,
    StSend   = 3'd3,
    StGap    = 3'd4,
    StDone   = 3'd5
  } tx_state_e;

endpackage

// File: rtl/uart_gap_timer.sv
// Load/count-down timer. expire_o pulses in the last counting cycle, so a load of N followed by
// N enabled cycles expires exactly on the Nth.
module uart_gap_timer
  import uart_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [GAP_CNT_W-1:0] load_val_i,
  input  logic                 en_i,
  output logic                 expire_o
);

  logic [GAP_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise count down while enabled and not yet empty.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - GAP_CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of 0 also expires so the timer can never stall the sequencer.
  assign expire_o = en_i && (cnt_q <= GAP_CNT_W'(1));

endmodule

// File: rtl/uart_tx_seq_ctrl.sv
// Transmit sequencer: on a trigger, fetches len bytes from the TX buffer and hands each one to
// the byte transmitter over valid/ready, then pulses done and reports the byte count.
module uart_tx_seq_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic [LEN_W-1:0]  data_length_i,
  input  logic              sent_trig_i,
  input  logic              abort_i,
  output logic              buf_rd_en_o,
  output logic [LEN_W-1:0]  buf_rd_addr_o,
  input  logic [BYTE_W-1:0] buf_rd_data_i,
  output logic [BYTE_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  byte_cnt_o,
  output logic              overrun_o
);

  localparam bit                   UseGap  = (GAP_CYCLES > 0);
  localparam logic [GAP_CNT_W-1:0] GapLoad = GAP_CNT_W'(GAP_CYCLES);

  tx_state_e         state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              rd_en_q, rd_en_d;
  logic [LEN_W-1:0]  rd_addr_q, rd_addr_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  // Remembers an abort seen mid-byte so it still ends the frame at the next acceptance.
  logic              abort_pend_q, abort_pend_d;

  logic              gap_load;
  logic              gap_en;
  logic              gap_expire;
  logic [LEN_W-1:0]  cnt_inc;

  assign cnt_inc = cnt_q + LEN_W'(1);

  if (UseGap) begin : g_gap
    uart_gap_timer u_gap_timer (
      .clk_i      (S_AXI_ACLK),
      .rst_ni     (S_AXI_ARESETN),
      .load_i     (gap_load),
      .load_val_i (GapLoad),
      .en_i       (gap_en),
      .expire_o   (gap_expire)
    );
  end else begin : g_no_gap
    logic unused_gap;
    assign unused_gap = gap_load ^ gap_en ^ (|GapLoad);
    assign gap_expire = 1'b0;
  end

  // Next-state and registered-output logic for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
    abort_pend_d = abort_pend_q;
    gap_load     = 1'b0;
    gap_en       = 1'b0;

    // Any trigger outside IDLE (including the DONE cycle) is dropped and flagged.
    if (sent_trig_i && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end
    if (abort_i && (state_q != StIdle)) begin
      abort_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (sent_trig_i) begin
          cnt_d        = '0;
          busy_d       = 1'b1;
          overrun_d    = 1'b0;
          abort_pend_d = 1'b0;
          if (data_length_i != '0) begin
            len_d     = data_length_i;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            state_d   = StFetch;
          end else begin
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StFetch: begin
        state_d = StWaitRd;
      end
      StWaitRd: begin
        tx_data_d  = buf_rd_data_i;
        tx_valid_d = 1'b1;
        state_d    = StSend;
      end
      StSend: begin
        // Valid is held until accepted regardless of abort.
        if (tx_ready_i) begin
          tx_valid_d = 1'b0;
          cnt_d      = cnt_inc;
          if ((cnt_inc == len_q) || abort_i || abort_pend_q) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else if (UseGap) begin
            gap_load = 1'b1;
            state_d  = StGap;
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = cnt_inc;
            state_d   = StFetch;
          end
        end
      end
      StGap: begin
        gap_en = 1'b1;
        if (abort_i || abort_pend_q) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else if (gap_expire) begin
          rd_en_d   = 1'b1;
          rd_addr_d = cnt_q;
          state_d   = StFetch;
        end
      end
      StDone: begin
        busy_d       = 1'b0;
        abort_pend_d = 1'b0;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset clears the frame immediately.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= StIdle;
      len_q        <= '0;
      cnt_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign buf_rd_en_o   = rd_en_q;
  assign buf_rd_addr_o = rd_addr_q;
  assign tx_data_o     = tx_data_q;
  assign tx_valid_o    = tx_valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign byte_cnt_o    = cnt_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_uart_tx_seq_ctrl.sv
// Bench for uart_tx_seq_ctrl: one instance without gap, one with a 3-cycle gap, both fed from a
// shared buffer image; results are compared against frame-level expectations.
module tb_uart_tx_seq_ctrl;

  localparam int unsigned LW = 10;
  localparam int unsigned GB = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] data_length = '0;
  logic          trig = 1'b0;
  logic          abort = 1'b0;
  logic          ready = 1'b1;

  logic          rd_en_a, tx_valid_a, busy_a, done_a, ovr_a;
  logic [LW-1:0] rd_addr_a, cnt_a;
  logic [7:0]    rd_data_a = '0, tx_data_a;
  logic          rd_en_b, tx_valid_b, busy_b, done_b, ovr_b;
  logic [LW-1:0] rd_addr_b, cnt_b;
  logic [7:0]    rd_data_b = '0, tx_data_b;

  logic [7:0] mem [1024];

  uart_tx_seq_ctrl #(.LEN_W(LW), .GAP_CYCLES(0)) u_dut_a (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .data_length_i (data_length),
    .sent_trig_i   (trig),
    .abort_i       (abort),
    .buf_rd_en_o   (rd_en_a),
    .buf_rd_addr_o (rd_addr_a),
    .buf_rd_data_i (rd_data_a),
    .tx_data_o     (tx_data_a),
    .tx_valid_o    (tx_valid_a),
    .tx_ready_i    (ready),
    .busy_o        (busy_a),
    .done_o        (done_a),
    .byte_cnt_o    (cnt_a),
    .overrun_o     (ovr_a)
  );

  uart_tx_seq_ctrl #(.LEN_W(LW), .GAP_CYCLES(GB)) u_dut_b (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .data_length_i (data_length),
    .sent_trig_i   (trig),
    .abort_i       (1'b0),
    .buf_rd_en_o   (rd_en_b),
    .buf_rd_addr_o (rd_addr_b),
    .buf_rd_data_i (rd_data_b),
    .tx_data_o     (tx_data_b),
    .tx_valid_o    (tx_valid_b),
    .tx_ready_i    (ready),
    .busy_o        (busy_b),
    .done_o        (done_b),
    .byte_cnt_o    (cnt_b),
    .overrun_o     (ovr_b)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem[rd_addr_b];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-frame observations.
  int          acc_a[$], rd_a[$], acc_b[$], rd_b[$];
  int unsigned rise_a[$], rise_b[$];
  int          done_n_a, done_n_b, stall_a;
  int unsigned done_cyc_a, done_cyc_b;
  logic        pv_a = 0, pr_a = 0, pv_b = 0, pr_b = 0;
  logic [7:0]  pd_a = 0, pd_b = 0;

  // Monitor: log handshakes, reads and done pulses; check valid/data hold during stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv_a = 0;
        pv_b = 0;
      end else begin
        if (pv_a && !pr_a) begin
          check_eq("a_hold_valid", tx_valid_a, 1);
          check_eq("a_hold_data", tx_data_a, pd_a);
        end
        if (tx_valid_a && !ready) stall_a++;
        if (tx_valid_a && !pv_a) rise_a.push_back(cyc);
        if (tx_valid_a && ready) acc_a.push_back(int'(tx_data_a));
        if (rd_en_a) rd_a.push_back(int'(rd_addr_a));
        if (done_a) begin done_n_a++; done_cyc_a = cyc; end
        pv_a = tx_valid_a; pr_a = ready; pd_a = tx_data_a;

        if (pv_b && !pr_b) begin
          check_eq("b_hold_valid", tx_valid_b, 1);
          check_eq("b_hold_data", tx_data_b, pd_b);
        end
        if (tx_valid_b && !pv_b) rise_b.push_back(cyc);
        if (tx_valid_b && ready) acc_b.push_back(int'(tx_data_b));
        if (rd_en_b) rd_b.push_back(int'(rd_addr_b));
        if (done_b) begin done_n_b++; done_cyc_b = cyc; end
        pv_b = tx_valid_b; pr_b = ready; pd_b = tx_data_b;
      end
    end
  end

  // Ready/abort driver: random ready, optional 6-cycle stall and one-cycle abort, both keyed
  // off instance A's read strobe.
  int rdy_pct = 100;
  int abort_arm = -1;
  int stall_left = 0;
  bit stall_arm = 0;
  bit abort_nxt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (stall_arm && rd_en_a && (rd_addr_a == LW'(1))) begin
        stall_left = 6;
        stall_arm = 0;
      end
      if ((abort_arm >= 0) && rd_en_a && (int'(rd_addr_a) == abort_arm)) begin
        abort_nxt = 1;
        abort_arm = -1;
      end
      @(posedge clk);
      #1;
      abort = abort_nxt;
      abort_nxt = 0;
      if (stall_left > 0) begin
        ready = 0;
        stall_left--;
      end else begin
        ready = ($urandom_range(99) < rdy_pct);
      end
    end
  end

  int unsigned t0;

  task automatic run_frame(input int len, input int pct, input int ab, input bit stall,
                           input bit mid_trig, input bit exp_ovr);
    int exp_n;
    int bound;
    acc_a.delete(); rd_a.delete(); rise_a.delete();
    acc_b.delete(); rd_b.delete(); rise_b.delete();
    done_n_a = 0; done_n_b = 0; stall_a = 0;
    rdy_pct = pct; abort_arm = ab; stall_arm = stall;
    @(posedge clk); #1;
    data_length = LW'(len);
    trig = 1;
    t0 = cyc;
    @(posedge clk); #1;
    trig = 0;
    data_length = LW'($urandom);
    if (mid_trig) begin
      @(posedge clk); #1 trig = 1;
      @(posedge clk); #1 trig = 0;
    end
    bound = 0;
    while (!((done_n_a > 0) && (done_n_b > 0)) && (bound < 3000)) begin
      @(posedge clk);
      bound++;
    end
    check_eq("frame_timeout", (bound < 3000), 1);
    repeat (3) @(posedge clk);
    #1;
    exp_n = ((ab >= 0) && (ab < len)) ? ab + 1 : len;
    check_eq("a_nbytes", acc_a.size(), exp_n);
    check_eq("a_nreads", rd_a.size(), exp_n);
    for (int i = 0; i < acc_a.size() && i < exp_n; i++) check_eq("a_byte", acc_a[i], mem[i]);
    for (int i = 0; i < rd_a.size() && i < exp_n; i++) check_eq("a_addr", rd_a[i], i);
    check_eq("a_byte_cnt", cnt_a, exp_n);
    check_eq("a_done_pulses", done_n_a, 1);
    check_eq("a_busy_end", busy_a, 0);
    check_eq("a_overrun", ovr_a, exp_ovr);
    check_eq("b_nbytes", acc_b.size(), len);
    check_eq("b_nreads", rd_b.size(), len);
    for (int i = 0; i < acc_b.size() && i < len; i++) check_eq("b_byte", acc_b[i], mem[i]);
    for (int i = 0; i < rd_b.size() && i < len; i++) check_eq("b_addr", rd_b[i], i);
    check_eq("b_byte_cnt", cnt_b, len);
    check_eq("b_done_pulses", done_n_b, 1);
    check_eq("b_overrun", ovr_b, exp_ovr);
    if ((pct == 100) && !stall) begin
      if (len == 0) begin
        check_eq("a_zero_done_lat", done_cyc_a - t0, 1);
        check_eq("b_zero_done_lat", done_cyc_b - t0, 1);
      end else begin
        if (rise_a.size() > 0) check_eq("a_first_valid_lat", rise_a[0] - t0, 3);
        for (int i = 1; i < rise_a.size(); i++)
          check_eq("a_byte_period", rise_a[i] - rise_a[i-1], 3);
        for (int i = 1; i < rise_b.size(); i++)
          check_eq("b_byte_period", rise_b[i] - rise_b[i-1], 3 + GB);
        check_eq("a_done_lat", done_cyc_a - t0, 3 * exp_n + 1);
        check_eq("b_done_lat", done_cyc_b - t0, 3 + (len - 1) * (3 + GB) + 1);
      end
    end
    abort_arm = -1;
    stall_arm = 0;
  endtask

  initial begin
    int bound;
    int len;
    int pct;
    int ab;
    bit mid;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;

    #12;
    check_eq("rst_outs_a", {rd_en_a, rd_addr_a, tx_data_a, tx_valid_a, busy_a, done_a, cnt_a,
                            ovr_a}, 0);
    check_eq("rst_outs_b", {rd_en_b, rd_addr_b, tx_data_b, tx_valid_b, busy_b, done_b, cnt_b,
                            ovr_b}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;

    run_frame(4, 100, -1, 0, 0, 0);           // basic frame, full throughput
    run_frame(3, 100, -1, 1, 0, 0);           // stall on byte 1
    check_eq("a_stall_cycles", stall_a, 5);
    run_frame(0, 100, -1, 0, 0, 0);           // zero length
    run_frame(10, 100, 2, 0, 0, 0);           // abort during WAIT_RD of byte 2
    run_frame(5, 100, -1, 0, 1, 1);           // trigger while busy sets overrun
    run_frame(2, 100, -1, 0, 0, 0);           // next accepted trigger clears it

    // Asynchronous reset in the middle of a held byte.
    rdy_pct = 0;
    @(posedge clk); #1;
    data_length = LW'(6);
    trig = 1;
    @(posedge clk); #1 trig = 0;
    bound = 0;
    while (!tx_valid_a && (bound < 100)) begin
      @(negedge clk);
      bound++;
    end
    check_eq("rst_wait_send", tx_valid_a, 1);
    #2 rst_n = 0;
    #1;
    check_eq("midrst_outs_a", {rd_en_a, rd_addr_a, tx_data_a, tx_valid_a, busy_a, done_a, cnt_a,
                               ovr_a}, 0);
    check_eq("midrst_outs_b", {rd_en_b, rd_addr_b, tx_data_b, tx_valid_b, busy_b, done_b, cnt_b,
                               ovr_b}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    run_frame(2, 100, -1, 0, 0, 0);

    // Randomized frames.
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(12, 1);
      pct = ($urandom_range(1, 0) == 0) ? 100 : $urandom_range(90, 40);
      ab  = ($urandom_range(2, 0) == 0) ? $urandom_range(len - 1, 0) : -1;
      mid = ($urandom_range(3, 0) == 0);
      run_frame(len, pct, ab, 0, mid, mid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_seq_ctrl.md
Name: uart_tx_seq_ctrl

Overview:
Transmit sequencer between the UART AXI register slave and the UART byte transmitter. On a trigger pulse it latches the programmed frame length and fetches bytes from the TX byte buffer, addresses 0..len-1. It hands each byte to the transmitter over a valid/ready handshake, then reports completion and status back to the register block.

Parameters:
LEN_W, 10, width of frame length, buffer address and byte counter
GAP_CYCLES, 0, idle cycles inserted after each accepted byte before the next fetch (0..255)

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
data_length_i  in  LEN_W  frame length in bytes, sampled only on an accepted trigger
sent_trig_i  in  1  single-cycle start pulse
abort_i  in  1  level; stop at the next byte boundary
buf_rd_en_o  out  1  buffer read strobe, 1 cycle wide
buf_rd_addr_o  out  LEN_W  buffer read address
buf_rd_data_i  in  8  buffer read data, valid 1 cycle after buf_rd_en_o
tx_data_o  out  8  byte to the transmitter
tx_valid_o  out  1  byte valid
tx_ready_i  in  1  transmitter accepts the byte
busy_o  out  1  frame in progress
done_o  out  1  1-cycle pulse at end of frame (normal, aborted or zero-length)
byte_cnt_o  out  LEN_W  bytes accepted in the current or last frame
overrun_o  out  1  sticky: trigger arrived while busy

Behaviour:
- Clock and reset are decided: one clock; reset is asynchronous and active-low. Ports are S_AXI_ACLK and S_AXI_ARESETN.
- Reset values: all outputs 0; FSM in IDLE. Reset asserted mid-frame clears everything immediately. No byte is resumed after reset.
- All outputs are registered.
- FSM states: IDLE, FETCH, WAIT_RD, SEND, GAP, DONE.
- IDLE:
  - sent_trig_i=1 and data_length_i≠0: latch len, byte_cnt_o←0, busy_o←1, overrun_o←0, go to FETCH.
  - sent_trig_i=1 and data_length_i=0: go to DONE with no buffer reads and byte_cnt_o=0.
- FETCH: buf_rd_en_o=1 for exactly one cycle, buf_rd_addr_o=byte_cnt_o, then WAIT_RD.
- WAIT_RD: tx_data_o←buf_rd_data_i, tx_valid_o←1, then SEND.
- Latency: trigger sampled at edge E0; buf_rd_en_o high in cycle E0..E1; tx_valid_o high from E2.
- SEND: tx_valid_o and tx_data_o hold stable until the edge where tx_valid_o & tx_ready_i. On that edge:
  - tx_valid_o←0 and byte_cnt_o increments.
  - If byte_cnt_o+1==len or abort_i=1, go to DONE.
  - Otherwise go to GAP if GAP_CYCLES>0, else FETCH.
- tx_valid_o never drops before acceptance, even when abort_i is asserted.
- GAP: count GAP_CYCLES cycles, then FETCH. abort_i seen in GAP goes to DONE.
- Abort reaction outside SEND:
  - abort_i in FETCH or WAIT_RD has no effect; the read byte is still sent.
  - abort_i is checked again at acceptance.
- DONE: done_o=1 for one cycle, busy_o←0, then IDLE. byte_cnt_o holds its value until the next accepted trigger.
- A trigger in the same cycle as done_o is treated as a trigger while busy and is not started.
- sent_trig_i while busy_o=1 (any state other than IDLE): ignored, overrun_o←1. The flag is cleared only by the next accepted trigger.
- Changes on data_length_i during a frame are ignored.
- Maximum len is 2^LEN_W-1. byte_cnt_o never wraps because it stops at len.
- Throughput with GAP_CYCLES=0 and tx_ready_i held high: one byte per 3 cycles.

Decomposition:
- Package uart_ctrl_pkg:
  - FSM state enum (3-bit encoding).
  - LEN_W default, BYTE_W=8.
  - Constant GAP_CNT_W=8.
- One sub-module, uart_gap_timer: load/count-down timer with a terminal pulse, GAP_CNT_W wide. It is bypassed when GAP_CYCLES=0.

Test Plan:
- len=4, buffer={A1,B2,C3,D4}, tx_ready_i=1, GAP=0:
  - Bytes A1,B2,C3,D4 are sent in order, every 3 cycles; the first tx_valid_o is at E2.
  - done_o pulses once; byte_cnt_o=4; busy_o falls with done_o.
- len=3, tx_ready_i low for 5 cycles on byte 1:
  - tx_valid_o and tx_data_o stay stable throughout the stall.
  - No extra buffer read is issued.
  - Completes with byte_cnt_o=3.
- len=0 trigger:
  - No buf_rd_en_o, no tx_valid_o.
  - done_o pulses 1 cycle after the trigger; byte_cnt_o=0.
- len=10, abort_i pulsed during the WAIT_RD of byte 2 (index 2):
  - Byte 2 is still sent.
  - Frame ends with byte_cnt_o=3 and a done_o pulse; no read at address 3.
- Second sent_trig_i during a 5-byte frame:
  - Current frame is unaffected; overrun_o=1 after the frame.
  - The next accepted trigger clears overrun_o.
- S_AXI_ARESETN asserted low mid-SEND (async, between edges), len=6:
  - All outputs go to 0 immediately.
  - After release, a new trigger with len=2 sends addresses 0,1 correctly.
